// File: rtl/axi4_duth_noc_ni_pkg.sv
// Shared types for the slave NI request path: flit types, sequencer states
// and the bit positions of the write/read channels in merge grants.
package axi4_duth_noc_ni_pkg;

    typedef enum logic [1:0] {
        HEAD   = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2,
        SINGLE = 2'd3
    } flit_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } seq_state_t;

    localparam int WR_CH = 0;
    localparam int RD_CH = 1;

endpackage

// File: rtl/axi_beat_counter.sv
// Remaining-beat counter: loads a burst length, counts down per beat and
// saturates at zero so a long burst can never wrap.
module axi_beat_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic [LEN_W-1:0] cnt,
    output logic             is_zero
);

    assign is_zero = (cnt == '0);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !is_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/axi_req_pkt_sequencer.sv
// Slave NI request sequencer: turns a merge grant into a header flit and,
// for writes, the following body/tail flits, then releases the merge lock.
module axi_req_pkt_sequencer
    import axi4_duth_noc_ni_pkg::*;
#(
    parameter bit HAS_WRITE = 1'b1,
    parameter bit HAS_READ  = 1'b1,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       active_channel,
    input  logic             anyactive,
    output logic [1:0]       update_pri,
    input  logic             aw_valid,
    input  logic [LEN_W-1:0] aw_len,
    output logic             aw_ready,
    input  logic             w_valid,
    input  logic             w_last,
    output logic             w_ready,
    input  logic             ar_valid,
    output logic             ar_ready,
    output logic             flit_valid,
    input  logic             flit_ready,
    output flit_type_t       flit_type,
    output logic             hdr_sel,
    output logic             hdr_is_read,
    output logic             err_last
);

    seq_state_t       state;
    logic [1:0]       chan_q;
    logic             rd_sel;
    logic             wr_sel;
    logic             flit_hs;
    logic [LEN_W-1:0] cnt;
    logic             cnt_zero;
    logic             unused_valid;

    // A grant is only ever issued for a pending request, so AW/AR valid add nothing here.
    assign unused_valid = aw_valid | ar_valid;

    assign rd_sel  = HAS_READ && chan_q[RD_CH];
    assign wr_sel  = HAS_WRITE && chan_q[WR_CH] && !chan_q[RD_CH];
    assign flit_hs = flit_valid && flit_ready;

    axi_beat_counter #(.LEN_W(LEN_W)) u_beat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     ((state == HDR) && wr_sel && flit_hs),
        .load_val (aw_len),
        .dec      ((state == DATA) && flit_hs),
        .cnt      (cnt),
        .is_zero  (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            chan_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyactive) begin
                        chan_q <= active_channel;
                        state  <= HDR;
                    end
                end
                HDR: begin
                    if (!rd_sel && !wr_sel) begin
                        state <= IDLE;
                    end else if (flit_hs) begin
                        state <= rd_sel ? IDLE : DATA;
                    end
                end
                DATA: begin
                    // Termination follows the beat counter; w_last is only checked.
                    if (flit_hs && cnt_zero) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        flit_valid  = 1'b0;
        flit_type   = HEAD;
        hdr_sel     = 1'b1;
        hdr_is_read = 1'b0;
        aw_ready    = 1'b0;
        w_ready     = 1'b0;
        ar_ready    = 1'b0;
        update_pri  = 2'b00;
        err_last    = 1'b0;
        case (state)
            HDR: begin
                if (rd_sel) begin
                    flit_valid         = 1'b1;
                    flit_type          = SINGLE;
                    hdr_is_read        = 1'b1;
                    ar_ready           = flit_ready;
                    update_pri[RD_CH]  = flit_ready;
                end else if (wr_sel) begin
                    flit_valid = 1'b1;
                    flit_type  = HEAD;
                    aw_ready   = flit_ready;
                end
            end
            DATA: begin
                hdr_sel    = 1'b0;
                flit_valid = w_valid;
                w_ready    = flit_ready;
                flit_type  = cnt_zero ? TAIL : BODY;
                if (w_valid && flit_ready) begin
                    err_last          = (w_last != cnt_zero);
                    update_pri[WR_CH] = cnt_zero;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_req_pkt_sequencer.sv
// Scoreboard bench for axi_req_pkt_sequencer: drivers push expected flits,
// a negedge monitor pops and compares every flit handshake.
module tb_axi_req_pkt_sequencer;
    import axi4_duth_noc_ni_pkg::*;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       active_channel = '0;
    logic             anyactive = 1'b0;
    logic [1:0]       update_pri;
    logic             aw_valid = 1'b0;
    logic [LEN_W-1:0] aw_len = '0;
    logic             aw_ready;
    logic             w_valid = 1'b0;
    logic             w_last = 1'b0;
    logic             w_ready;
    logic             ar_valid = 1'b0;
    logic             ar_ready;
    logic             flit_valid;
    logic             flit_ready = 1'b1;
    flit_type_t       flit_type;
    logic             hdr_sel;
    logic             hdr_is_read;
    logic             err_last;

    axi_req_pkt_sequencer #(.HAS_WRITE(1'b1), .HAS_READ(1'b1), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .active_channel(active_channel), .anyactive(anyactive),
        .update_pri(update_pri), .aw_valid(aw_valid), .aw_len(aw_len), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_last(w_last), .w_ready(w_ready), .ar_valid(ar_valid),
        .ar_ready(ar_ready), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .flit_type(flit_type), .hdr_sel(hdr_sel), .hdr_is_read(hdr_is_read), .err_last(err_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ftype;
        logic       hsel;
        logic       rd;
        logic       err;
        logic [1:0] pri;
        logic [2:0] rdy;   // {ar_ready, aw_ready, w_ready}
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_final = -1;
    bit   prev_stall = 1'b0;
    logic [1:0] prev_type = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input logic [1:0] t, input logic err, input logic [1:0] pri);
        exp_t x;
        x.ftype = t;
        x.hsel  = (t == HEAD) || (t == SINGLE);
        x.rd    = (t == SINGLE);
        x.err   = err;
        x.pri   = pri;
        x.rdy   = (t == SINGLE) ? 3'b100 : (t == HEAD) ? 3'b010 : 3'b001;
        sb.push_back(x);
    endfunction

    // Monitor: compares each flit handshake against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            last_final = -1;
        end else begin
            if (prev_stall)
                check("stall_hold", 16'({flit_valid, flit_type}), 16'({1'b1, prev_type}));
            if (flit_valid && flit_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_flit", 16'(flit_type), 16'hffff);
                end else begin
                    e = sb.pop_front();
                    check("flit",
                          16'({flit_type, hdr_sel, hdr_is_read, err_last, update_pri, ar_ready, aw_ready, w_ready}),
                          16'({e.ftype, e.hsel, e.rd, e.err, e.pri, e.rdy}));
                end
                if ((flit_type == HEAD || flit_type == SINGLE) && last_final >= 0)
                    check("hdr_gap_ge2", 16'(cyc - last_final >= 2), 16'd1);
                if (update_pri != 2'b00) last_final = cyc;
            end else begin
                check("no_pulse_no_overlap",
                      16'({update_pri, err_last, ar_ready && (aw_ready || w_ready)}), 16'd0);
            end
            prev_stall = flit_valid && !flit_ready;
            prev_type  = flit_type;
        end
    end

    task automatic check_reset_outputs(input string name);
        check(name,
              16'({flit_valid, flit_type, hdr_sel, hdr_is_read, aw_ready, w_ready, ar_ready, update_pri, err_last}),
              16'({1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0}));
    endtask

    task automatic run_read();
        push(SINGLE, 1'b0, 2'b10);
        @(posedge clk); #1;
        anyactive = 1'b1; active_channel = 2'b10; ar_valid = 1'b1; flit_ready = 1'b1;
        @(negedge clk);
        check("rd_decision_cycle", 16'({flit_valid, ar_ready}), 16'd0);
        @(negedge clk);
        check("rd_latency", 16'({flit_valid, flit_type, ar_ready, update_pri}), 16'({1'b1, SINGLE, 1'b1, 2'b10}));
        @(posedge clk); #1;
        ar_valid = 1'b0; anyactive = 1'b0; active_channel = 2'b00;
        @(negedge clk);
        check("rd_back_idle", 16'({flit_valid, ar_ready}), 16'd0);
    endtask

    // Writes one burst of len+1 beats; w_last on beat last_at; bp toggles flit_ready;
    // gap idle cycles precede each beat; abort_after>=0 returns after that many beats.
    task automatic run_write(input int len, input int last_at, input bit bp, input int gap,
                             input int abort_after);
        int beats = 0;
        int wait_cnt = gap;
        int t = 0;
        bit aw_done = 1'b0;
        bit done = 1'b0;
        bit hs_aw, hs_w, fin;
        push(HEAD, 1'b0, 2'b00);
        for (int b = 0; b <= len; b++)
            push((b == len) ? TAIL : BODY, (b == last_at) != (b == len), (b == len) ? 2'b01 : 2'b00);
        @(posedge clk); #1;
        anyactive = 1'b1; active_channel = 2'b01; aw_valid = 1'b1;
        aw_len = LEN_W'(len); flit_ready = 1'b1;
        while (!done) begin
            @(negedge clk);
            hs_aw = aw_valid && aw_ready;
            hs_w  = w_valid && w_ready;
            fin   = update_pri[0];
            @(posedge clk); #1;
            t++;
            if (hs_aw) begin aw_valid = 1'b0; aw_done = 1'b1; end
            if (hs_w) begin beats++; w_valid = 1'b0; w_last = 1'b0; wait_cnt = gap; end
            if (fin) begin
                anyactive = 1'b0; active_channel = 2'b00; done = 1'b1;
            end else if (abort_after >= 0 && beats == abort_after) begin
                done = 1'b1;
            end else if (t > 200) begin
                check("write_timeout", 16'(t), 16'd0);
                done = 1'b1;
            end else begin
                if (aw_done && !w_valid && beats <= len) begin
                    if (wait_cnt > 0) wait_cnt--;
                    else begin w_valid = 1'b1; w_last = (beats == last_at); end
                end
                if (bp) flit_ready = !flit_ready;
            end
        end
        flit_ready = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_outputs");
        @(posedge clk); #1;
        rst = 1'b0;

        run_read();                      // read only: SINGLE, update_pri=10
        run_write(3, 3, 1'b0, 0, -1);    // HEAD BODY BODY BODY TAIL, no error
        run_write(1, 1, 1'b1, 2, -1);    // backpressure + W gaps, 3 flits
        run_write(2, 0, 1'b0, 0, -1);    // early w_last: err on beats 1 and 3, TAIL on 3
        ar_valid = 1'b1;                 // read pending behind a write
        run_write(4, 4, 1'b0, 1, -1);
        run_read();
        run_write(7, 7, 1'b0, 0, 2);     // stop in DATA with cnt=5

        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_burst_reset");
        sb.delete();
        anyactive = 1'b0; active_channel = 2'b00; aw_valid = 1'b0;
        w_valid = 1'b0; w_last = 1'b0; ar_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_write(0, 0, 1'b0, 0, -1);    // clean restart: HEAD then one TAIL
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
